// File: rtl/uart_rx_mon_pkg.sv
// Shared types and constants for the UART receive monitor.
// Holds the receiver state encoding, error bit positions and the parity helper.
package uart_rx_mon_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int ERR_FRAME    = 0;
  localparam int ERR_PARITY   = 1;
  localparam int MIN_PRESCALE = 4;

  // A set result means the data parity combined with the received parity bit
  // disagrees with the selected sense.
  function automatic logic parity_error(input logic data_xor,
                                        input logic par_bit,
                                        input logic par_odd);
    return (data_xor ^ par_bit) != par_odd;
  endfunction

endpackage

// File: rtl/uart_rx_mon_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_mon_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (wptr_r == rptr_r);
  assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign level     = wptr_r - rptr_r;
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign rdata     = mem_r[rptr_r[AW-1:0]];

  // Storage and pointer update
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r[AW-1:0]] <= wdata;
        wptr_r                <= wptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_rx_mon.sv
// UART receive monitor: synchroniser, mid-bit sampling FSM and error-tagged receive FIFO.
// Frames are pushed as {parity_err, frame_err, data} at the stop-bit sample point.
module uart_rx_mon
  import uart_rx_mon_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          en,
  input  logic [PRESCALE_W-1:0]         prescale,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          rx,
  input  logic                          rd,
  input  logic                          clr,
  output logic [DATA_W-1:0]             rdata,
  output logic [1:0]                    rerr,
  output logic                          rvalid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic                          busy
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int FW    = DATA_W + 2;
  localparam logic [PRESCALE_W-1:0] MIN_P   = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [PRESCALE_W-1:0] CNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] CNT_ZERO = {PRESCALE_W{1'b0}};
  localparam logic [IDX_W-1:0]      IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(DATA_W - 1);

  logic                  sync1_r, sync2_r, prev_r;
  logic                  rxs_s, fall_s, bit_due_s;
  logic [PRESCALE_W-1:0] p_eff_s, half_s, full_s;
  rx_state_e             state_r, state_n;
  logic [PRESCALE_W-1:0] bcnt_r, bcnt_n;
  logic [IDX_W-1:0]      bidx_r, bidx_n;
  logic [DATA_W-1:0]     shreg_r, shreg_n;
  logic                  perr_r, perr_n;
  logic                  push_s, ferr_s, ovf_s;
  logic [1:0]            err_s;
  logic                  overrun_r, busy_r;
  logic                  fifo_full_s, fifo_empty_s;
  logic [FW-1:0]         fifo_rdata_s;

  assign rxs_s     = sync2_r;
  assign fall_s    = prev_r & ~rxs_s;
  assign p_eff_s   = (prescale < MIN_P) ? MIN_P : prescale;
  assign half_s    = (p_eff_s >> 1) - CNT_ONE;
  assign full_s    = p_eff_s - CNT_ONE;
  assign bit_due_s = (bcnt_r == CNT_ZERO);

  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Receiver next-state, counter, shift and push decode
  always_comb begin
    state_n = state_r;
    bcnt_n  = bcnt_r;
    bidx_n  = bidx_r;
    shreg_n = shreg_r;
    perr_n  = perr_r;
    push_s  = 1'b0;
    ferr_s  = 1'b0;
    if (!en) begin
      state_n = IDLE;
      bidx_n  = {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            bcnt_n  = half_s;
            bidx_n  = {IDX_W{1'b0}};
            perr_n  = 1'b0;
            state_n = START;
          end else begin
            bcnt_n  = CNT_ZERO;
          end
        end
        START: begin
          if (!bit_due_s) begin
            bcnt_n = bcnt_r - CNT_ONE;
          end else if (rxs_s) begin
            state_n = IDLE;  // start bit did not hold: glitch
          end else begin
            bcnt_n  = full_s;
            state_n = DATA;
          end
        end
        DATA: begin
          if (!bit_due_s) begin
            bcnt_n = bcnt_r - CNT_ONE;
          end else begin
            shreg_n[bidx_r] = rxs_s;
            bcnt_n          = full_s;
            if (bidx_r == IDX_LAST) begin
              bidx_n  = {IDX_W{1'b0}};
              state_n = parity_en ? PARITY : STOP;
            end else begin
              bidx_n  = bidx_r + IDX_ONE;
            end
          end
        end
        PARITY: begin
          if (!bit_due_s) begin
            bcnt_n = bcnt_r - CNT_ONE;
          end else begin
            perr_n  = parity_error(^shreg_r, rxs_s, parity_odd);
            bcnt_n  = full_s;
            state_n = STOP;
          end
        end
        STOP: begin
          if (!bit_due_s) begin
            bcnt_n = bcnt_r - CNT_ONE;
          end else begin
            push_s  = 1'b1;
            ferr_s  = ~rxs_s;
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Receiver state registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= IDLE;
      bcnt_r  <= CNT_ZERO;
      bidx_r  <= {IDX_W{1'b0}};
      shreg_r <= {DATA_W{1'b0}};
      perr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      bcnt_r  <= bcnt_n;
      bidx_r  <= bidx_n;
      shreg_r <= shreg_n;
      perr_r  <= perr_n;
      busy_r  <= (state_n != IDLE);
    end
  end

  assign ovf_s = push_s & fifo_full_s & ~rd;

  // Sticky overrun; a new drop wins over a simultaneous clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= ovf_s | (overrun_r & ~clr);
    end
  end

  always_comb begin
    err_s             = 2'b00;
    err_s[ERR_PARITY] = perr_r;
    err_s[ERR_FRAME]  = ferr_s;
  end

  uart_rx_mon_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (push_s),
    .wdata   ({err_s, shreg_r}),
    .pop     (rd),
    .rdata   (fifo_rdata_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (level)
  );

  assign rdata   = fifo_rdata_s[DATA_W-1:0];
  assign rerr    = fifo_rdata_s[DATA_W +: 2];
  assign rvalid  = ~fifo_empty_s;
  assign overrun = overrun_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_uart_rx_mon.sv
// Self-checking bench for uart_rx_mon: vector table, directed corner sequences
// and randomized frames checked against a queue-based reference model.
module tb_uart_rx_mon;

  logic        HCLK = 1'b0;
  logic        HRESETn, en, parity_en, parity_odd, rx, rd, clr;
  logic [15:0] prescale;
  logic [7:0]  rdata;
  logic [1:0]  rerr;
  logic        rvalid, overrun, busy;
  logic [3:0]  level;

  logic        rx7, rd7;
  logic [15:0] prescale7;
  logic [6:0]  rdata7;
  logic [1:0]  rerr7;
  logic        rvalid7, overrun7, busy7;
  logic [3:0]  level7;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int frame_cyc = 0;
  int first_valid = -1;
  logic sel7 = 1'b0;

  always #5 HCLK = ~HCLK;

  uart_rx_mon #(.DATA_W(8), .FIFO_DEPTH(8), .PRESCALE_W(16)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .prescale(prescale),
    .parity_en(parity_en), .parity_odd(parity_odd), .rx(rx), .rd(rd), .clr(clr),
    .rdata(rdata), .rerr(rerr), .rvalid(rvalid), .level(level),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_mon #(.DATA_W(7), .FIFO_DEPTH(8), .PRESCALE_W(16)) u_dut7 (
    .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .prescale(prescale7),
    .parity_en(parity_en), .parity_odd(parity_odd), .rx(rx7), .rd(rd7), .clr(clr),
    .rdata(rdata7), .rerr(rerr7), .rvalid(rvalid7), .level(level7),
    .overrun(overrun7), .busy(busy7)
  );

  typedef struct {
    logic [7:0] data;
    int         presc;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs[8];
  logic [9:0] model_q[$];
  logic       exp_ovr;

  task automatic tick();
    @(posedge HCLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    if (sel7) rx7 = v; else rx = v;
    for (int i = 0; i < n; i++) begin
      tick();
      if (first_valid < 0 && rvalid) first_valid = cyc - frame_cyc;
    end
  endtask

  function automatic int eff_p(input int p);
    return (p < 4) ? 4 : p;
  endfunction

  task automatic send_frame(input logic [7:0] d, input int nbits, input int p,
                            input logic pen, input logic pbit, input logic stop);
    frame_cyc   = cyc;
    first_valid = -1;
    hold(1'b0, p);
    for (int i = 0; i < nbits; i++) hold(d[i], p);
    if (pen) hold(pbit, p);
    hold(stop, p);
    hold(1'b1, 4);
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  // Reference: expected error bits from the frame contents
  function automatic logic [1:0] ref_err(input logic [7:0] d, input logic pen,
                                         input logic podd, input logic pbit, input logic stop);
    logic pe;
    pe = pen && ((($countones(d) + int'(pbit)) % 2) != int'(podd));
    return {pe, ~stop};
  endfunction

  initial begin
    vecs[0] = '{8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 2'b00};
    vecs[1] = '{8'hA3, 16, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 2'b10};
    vecs[2] = '{8'hA3, 16, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 2'b00};
    vecs[3] = '{8'h3C, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 2'b01};
    vecs[4] = '{8'h0F,  8, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, 2'b00};
    vecs[5] = '{8'h80,  6, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 2'b00};
    vecs[6] = '{8'hFF,  2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 2'b00};
    vecs[7] = '{8'h00, 12, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'b11};

    HRESETn = 1'b0; en = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    rx = 1'b1; rd = 1'b0; clr = 1'b0; prescale = 16'd16;
    rx7 = 1'b1; rd7 = 1'b0; prescale7 = 16'd3;
    tick(); tick();
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_rerr", 32'(rerr), 32'd0);
    HRESETn = 1'b1;
    tick(); tick();

    // Table-driven single frames
    for (int v = 0; v < 8; v++) begin
      prescale   = 16'(vecs[v].presc);
      parity_en  = vecs[v].pen;
      parity_odd = vecs[v].podd;
      send_frame(vecs[v].data, 8, eff_p(vecs[v].presc), vecs[v].pen, vecs[v].pbit, vecs[v].stop);
      if (v == 0) check("latency_le_155", 32'(first_valid >= 140 && first_valid <= 155), 32'd1);
      check($sformatf("vec%0d_rvalid", v), 32'(rvalid), 32'd1);
      check($sformatf("vec%0d_level", v), 32'(level), 32'd1);
      check($sformatf("vec%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_rerr", v), 32'(rerr), 32'(vecs[v].exp_err));
      pop();
      check($sformatf("vec%0d_pop_rvalid", v), 32'(rvalid), 32'd0);
      check($sformatf("vec%0d_pop_level", v), 32'(level), 32'd0);
    end

    // Break: stop bit low and rx held low must not retrigger
    parity_en = 1'b0; prescale = 16'd10;
    hold(1'b0, 10);
    for (int i = 0; i < 8; i++) hold(logic'((8'h3C >> i) & 8'h01), 10);
    hold(1'b0, 60);
    check("break_level", 32'(level), 32'd1);
    check("break_busy", 32'(busy), 32'd0);
    check("break_rerr", 32'(rerr), 32'd1);
    hold(1'b1, 5);
    send_frame(8'hC3, 8, 10, 1'b0, 1'b0, 1'b1);
    check("rearm_level", 32'(level), 32'd2);
    pop();
    check("rearm_head", 32'(rdata), 32'hC3);
    check("rearm_err", 32'(rerr), 32'd0);
    pop();

    // Start-bit glitch
    prescale = 16'd16;
    hold(1'b0, 3);
    check("glitch_busy_rise", 32'(busy), 32'd1);
    hold(1'b1, 40);
    check("glitch_busy_fall", 32'(busy), 32'd0);
    check("glitch_level", 32'(level), 32'd0);

    // Enable dropped mid-frame
    hold(1'b0, 30);
    en = 1'b0;
    tick(); tick();
    check("en_drop_busy", 32'(busy), 32'd0);
    hold(1'b1, 20);
    en = 1'b1;
    tick();
    check("en_drop_level", 32'(level), 32'd0);

    // Overrun: nine frames into eight entries
    prescale = 16'd8;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 8, 8, 1'b0, 1'b0, 1'b1);
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_overrun", 32'(overrun), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovf_pop%0d", i), 32'(rdata), 32'(i));
      pop();
    end
    check("ovf_empty", 32'(rvalid), 32'd0);
    check("ovf_sticky", 32'(overrun), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("ovf_clr", 32'(overrun), 32'd0);

    // Randomized frames against the queue model
    exp_ovr = 1'b0;
    for (int f = 0; f < 30; f++) begin
      logic [7:0] d;
      logic pen, podd, pbit, stop;
      int p;
      d    = 8'($urandom_range(0, 255));
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      pbit = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      p    = $urandom_range(1, 12);
      prescale = 16'(p); parity_en = pen; parity_odd = podd;
      send_frame(d, 8, eff_p(p), pen, pbit, stop);
      if (model_q.size() == 8) exp_ovr = 1'b1;
      else model_q.push_back({ref_err(d, pen, podd, pbit, stop), d});
      check($sformatf("rnd%0d_level", f), 32'(level), 32'(model_q.size()));
      check($sformatf("rnd%0d_overrun", f), 32'(overrun), 32'(exp_ovr));
      if ($urandom_range(0, 2) == 0 && model_q.size() > 0) begin
        check($sformatf("rnd%0d_data", f), 32'({rerr, rdata}), 32'(model_q[0]));
        void'(model_q.pop_front());
        pop();
      end
    end
    while (model_q.size() > 0) begin
      check("drain_data", 32'({rerr, rdata}), 32'(model_q[0]));
      void'(model_q.pop_front());
      pop();
    end
    check("drain_empty", 32'(rvalid), 32'd0);
    clr = 1'b1; tick(); clr = 1'b0;

    // Reset mid-DATA with entries queued
    parity_en = 1'b0; prescale = 16'd8;
    for (int i = 0; i < 3; i++) send_frame(8'(8'h10 + i), 8, 8, 1'b0, 1'b0, 1'b1);
    check("pre_reset_level", 32'(level), 32'd3);
    hold(1'b0, 8); hold(1'b1, 8); hold(1'b0, 6);
    check("pre_reset_busy", 32'(busy), 32'd1);
    HRESETn = 1'b0;
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rx = 1'b1;
    tick();
    HRESETn = 1'b1;
    tick(); tick();
    send_frame(8'h7E, 8, 8, 1'b0, 1'b0, 1'b1);
    check("post_rst_level", 32'(level), 32'd1);
    check("post_rst_data", 32'(rdata), 32'h7E);
    check("post_rst_err", 32'(rerr), 32'd0);
    pop();

    // Seven-bit instance with clamped prescale
    sel7 = 1'b1;
    send_frame(8'h5A, 7, 4, 1'b0, 1'b0, 1'b1);
    sel7 = 1'b0;
    check("w7_rvalid", 32'(rvalid7), 32'd1);
    check("w7_data", 32'(rdata7), 32'h5A);
    check("w7_err", 32'(rerr7), 32'd0);
    check("w7_level", 32'(level7), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
